// File: rtl/filt_cic_ctrl.sv
// filt_cic_ctrl - sequencing controller for one CIC decimator.
//
// Gates the integrator enable with a valid/ready accept rule and generates the
// decimation strobe every D accepted inputs. It throws away the comb warm-up
// results and registers each decimated sample behind a lossless valid/ready
// output stage.
//
// Ports
//   i_clk, i_rst_an     clock (rising edge), synchronous active-low reset
//   i_start, i_stop     start / stop request pulses
//   i_decim             decimation factor D, latched on an accepted start
//   i_in_valid          source sample valid
//   o_in_ready          source sample accepted when i_in_valid & o_in_ready
//   o_cic_clr           one-cycle filter clear
//   o_cic_ena           integrator enable (accepted input)
//   o_dec_strobe        comb / downsample enable
//   i_cic_data          filter comb result
//   o_data, o_valid     decimated sample and its valid
//   i_ready             consumer ready
//   o_busy              controller not idle
//   o_err               sticky illegal-D flag, cleared by the next legal start
//
// state     | meaning
// s_idle    | waiting for a legal start; no inputs accepted
// s_clear   | one-cycle filter clear; phase and warm-up counters reloaded
// s_warmup  | filter running; first N = order*delay results discarded
// s_run     | filter running; decimated results delivered downstream
module filt_cic_ctrl #(
  parameter int gp_max_decim  = 16,
  parameter int gp_order      = 3,
  parameter int gp_diff_delay = 1,
  parameter int gp_data_width = 20,
  parameter int gp_dec_width  = $clog2(gp_max_decim + 1)
) (
  input  logic                     i_clk,
  input  logic                     i_rst_an,
  input  logic                     i_start,
  input  logic                     i_stop,
  input  logic [gp_dec_width-1:0]  i_decim,
  input  logic                     i_in_valid,
  output logic                     o_in_ready,
  output logic                     o_cic_clr,
  output logic                     o_cic_ena,
  output logic                     o_dec_strobe,
  input  logic [gp_data_width-1:0] i_cic_data,
  output logic [gp_data_width-1:0] o_data,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic                     o_busy,
  output logic                     o_err
);

  typedef enum logic [1:0] {
    s_idle   = 2'd0,
    s_clear  = 2'd1,
    s_warmup = 2'd2,
    s_run    = 2'd3
  } state_t;

  // Warm-up length equals the comb pipeline depth of the controlled filter.
  localparam int lp_warm_n = gp_order * gp_diff_delay;
  localparam int lp_warm_w = (lp_warm_n < 2) ? 1 : $clog2(lp_warm_n + 1);
  localparam logic [lp_warm_w-1:0]    lp_warm_load = lp_warm_w'(lp_warm_n);
  localparam logic [lp_warm_w-1:0]    lp_warm_one  = lp_warm_w'(1);
  localparam logic [gp_dec_width-1:0] lp_dec_one   = gp_dec_width'(1);
  localparam logic [gp_dec_width-1:0] lp_dec_min   = gp_dec_width'(2);
  localparam logic [gp_dec_width-1:0] lp_dec_max   = gp_dec_width'(gp_max_decim);

  state_t state_q, state_d;

  logic [gp_dec_width-1:0]  dec_q;
  logic [gp_dec_width-1:0]  dec_last;
  // Down-counter: accepted inputs remaining before the next strobe (0 = strobe).
  logic [gp_dec_width-1:0]  phase_q;
  // Down-counter: warm-up strobes remaining (1 = last discarded strobe).
  logic [lp_warm_w-1:0]     warm_q;
  logic                     err_q;
  logic                     pend_q;
  logic                     pend_keep_q;
  logic                     valid_q;
  logic [gp_data_width-1:0] data_q;

  logic start_ok;
  logic decim_legal;
  logic phase_tc;
  logic warm_tc;
  logic out_stall;
  logic in_ready;
  logic cic_ena;
  logic dec_strobe;
  logic cic_clr;
  logic busy;

  assign start_ok    = i_start & ~i_stop;
  assign decim_legal = (i_decim >= lp_dec_min) && (i_decim <= lp_dec_max);
  assign dec_last    = dec_q - lp_dec_one;
  assign phase_tc    = (phase_q == '0);
  assign warm_tc     = (warm_q == lp_warm_one);
  // The strobe input is held back while the output register cannot take a
  // new result, or while the previous result is still one cycle in flight.
  assign out_stall   = (valid_q & ~i_ready) | pend_q;

  always_ff @(posedge i_clk) begin
    if (!i_rst_an) begin
      state_q <= s_idle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      s_idle: begin
        if (start_ok && decim_legal) begin
          state_d = s_clear;
        end
      end
      s_clear: begin
        state_d = i_stop ? s_idle : s_warmup;
      end
      s_warmup: begin
        if (i_stop) begin
          state_d = s_idle;
        end else if (dec_strobe && warm_tc) begin
          state_d = s_run;
        end
      end
      s_run: begin
        if (i_stop) begin
          state_d = s_idle;
        end
      end
      default: state_d = s_idle;
    endcase
  end

  always_comb begin
    in_ready = 1'b0;
    cic_clr  = 1'b0;
    busy     = 1'b0;
    case (state_q)
      s_clear: begin
        cic_clr = 1'b1;
        busy    = 1'b1;
      end
      s_warmup, s_run: begin
        in_ready = ~(phase_tc & out_stall);
        busy     = 1'b1;
      end
      default: ;
    endcase
    cic_ena    = i_in_valid & in_ready;
    dec_strobe = cic_ena & phase_tc;
  end

  assign o_in_ready   = in_ready;
  assign o_cic_ena    = cic_ena;
  assign o_dec_strobe = dec_strobe;
  assign o_cic_clr    = cic_clr;
  assign o_busy       = busy;
  assign o_err        = err_q;
  assign o_data       = data_q;
  assign o_valid      = valid_q;

  always_ff @(posedge i_clk) begin
    if (!i_rst_an) begin
      dec_q       <= lp_dec_min;
      err_q       <= 1'b0;
      phase_q     <= '0;
      warm_q      <= '0;
      pend_q      <= 1'b0;
      pend_keep_q <= 1'b0;
      valid_q     <= 1'b0;
      data_q      <= '0;
    end else begin
      if ((state_q == s_idle) && start_ok) begin
        if (decim_legal) begin
          dec_q <= i_decim;
          err_q <= 1'b0;
        end else begin
          err_q <= 1'b1;
        end
      end

      if (state_q == s_clear) begin
        phase_q <= dec_last;
        warm_q  <= lp_warm_load;
      end else begin
        if (cic_ena) begin
          phase_q <= phase_tc ? dec_last : (phase_q - lp_dec_one);
        end
        if ((state_q == s_warmup) && dec_strobe && !warm_tc) begin
          warm_q <= warm_q - lp_warm_one;
        end
      end

      // pend_keep marks results that are delivered; warm-up results, the
      // strobe that ends warm-up and a strobe in a stop cycle are dropped.
      pend_q      <= dec_strobe & ~i_stop;
      pend_keep_q <= dec_strobe & ~i_stop & (state_q == s_run);

      if (pend_keep_q) begin
        data_q  <= i_cic_data;
        valid_q <= 1'b1;
      end else if (i_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_filt_cic_ctrl.sv
module tb_filt_cic_ctrl;

  localparam int DW   = 20;
  localparam int DECW = 5;
  localparam int WARM = 3;   // order 3 * differential delay 1
  localparam int DMAX = 16;

  logic            i_clk = 1'b0;
  logic            i_rst_an;
  logic            i_start;
  logic            i_stop;
  logic [DECW-1:0] i_decim;
  logic            i_in_valid;
  logic            o_in_ready;
  logic            o_cic_clr;
  logic            o_cic_ena;
  logic            o_dec_strobe;
  logic [DW-1:0]   i_cic_data;
  logic [DW-1:0]   o_data;
  logic            o_valid;
  logic            i_ready;
  logic            o_busy;
  logic            o_err;

  filt_cic_ctrl #(
    .gp_max_decim (16),
    .gp_order     (3),
    .gp_diff_delay(1),
    .gp_data_width(DW),
    .gp_dec_width (DECW)
  ) dut (
    .i_clk       (i_clk),
    .i_rst_an    (i_rst_an),
    .i_start     (i_start),
    .i_stop      (i_stop),
    .i_decim     (i_decim),
    .i_in_valid  (i_in_valid),
    .o_in_ready  (o_in_ready),
    .o_cic_clr   (o_cic_clr),
    .o_cic_ena   (o_cic_ena),
    .o_dec_strobe(o_dec_strobe),
    .i_cic_data  (i_cic_data),
    .o_data      (o_data),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_busy      (o_busy),
    .o_err       (o_err)
  );

  always #5 i_clk = ~i_clk;

  // Order-3, delay-1 CIC filter driven by the controller (modular arithmetic).
  logic [DW-1:0] src_x;
  logic [DW-1:0] ig1, ig2, ig3, dl1, dl2, dl3;
  logic [DW-1:0] ig1_n, ig2_n, ig3_n, cb1_n, cb2_n, cb3_n;
  assign ig1_n = ig1 + src_x;
  assign ig2_n = ig2 + ig1_n;
  assign ig3_n = ig3 + ig2_n;
  assign cb1_n = ig3_n - dl1;
  assign cb2_n = cb1_n - dl2;
  assign cb3_n = cb2_n - dl3;

  always @(posedge i_clk) begin
    if (!i_rst_an || o_cic_clr) begin
      ig1 <= '0; ig2 <= '0; ig3 <= '0;
      dl1 <= '0; dl2 <= '0; dl3 <= '0;
      i_cic_data <= '0;
    end else if (o_cic_ena) begin
      ig1 <= ig1_n; ig2 <= ig2_n; ig3 <= ig3_n;
      if (o_dec_strobe) begin
        dl1 <= ig3_n; dl2 <= cb1_n; dl3 <= cb2_n;
        i_cic_data <= cb3_n;
      end
    end
  end

  // Behavioural controller model: states as the spec names them, phase as an
  // up-counter modulo D, warm-up as a count of strobes seen.
  int            m_st;      // 0 idle, 1 clear, 2 warmup, 3 run
  int            m_d, m_phase, m_wcnt;
  bit            m_err, m_pend, m_keep, m_valid;
  logic [DW-1:0] m_data;
  bit            e_ready, e_ena, e_strobe;

  int  n_tests = 0;
  int  n_fail  = 0;
  int  cyc     = 0;
  bit  chk_en  = 1'b0;
  int  n_clr;
  int  strobe_q[$];
  int  first_valid;
  logic [DW-1:0] first_data;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_d = 2; m_phase = 0; m_wcnt = 0;
    m_err = 0; m_pend = 0; m_keep = 0; m_valid = 0; m_data = '0;
  endtask

  task automatic model_comb();
    bit act;
    bit at_last;
    act      = (m_st == 2) || (m_st == 3);
    at_last  = (m_phase == m_d - 1);
    e_ready  = act && !(at_last && ((m_valid && !i_ready) || m_pend));
    e_ena    = e_ready && i_in_valid;
    e_strobe = e_ena && at_last;
  endtask

  task automatic model_edge();
    bit n_pend;
    bit n_keep;
    if (!i_rst_an) begin
      model_reset();
      return;
    end
    if (m_keep) begin
      m_data  = i_cic_data;
      m_valid = 1;
    end else if (m_valid && i_ready) begin
      m_valid = 0;
    end
    n_pend = e_strobe && !i_stop;
    n_keep = e_strobe && !i_stop && (m_st == 3);
    if (m_st == 1) m_phase = 0;
    else if (e_ena) m_phase = (m_phase + 1) % m_d;
    case (m_st)
      0: if (i_start && !i_stop) begin
           if (i_decim >= 2 && i_decim <= DMAX) begin
             m_d = int'(i_decim); m_err = 0; m_st = 1;
           end else begin
             m_err = 1;
           end
         end
      1: begin m_wcnt = 0; m_st = i_stop ? 0 : 2; end
      2: if (i_stop) m_st = 0;
         else if (e_strobe) begin
           m_wcnt++;
           if (m_wcnt == WARM) m_st = 3;
         end
      default: if (i_stop) m_st = 0;
    endcase
    m_pend = n_pend;
    m_keep = n_keep;
  endtask

  task automatic compare();
    model_comb();
    chk("in_ready",   32'(o_in_ready),   32'(e_ready));
    chk("cic_ena",    32'(o_cic_ena),    32'(e_ena));
    chk("dec_strobe", 32'(o_dec_strobe), 32'(e_strobe));
    chk("cic_clr",    32'(o_cic_clr),    32'(m_st == 1));
    chk("busy",       32'(o_busy),       32'(m_st != 0));
    chk("err",        32'(o_err),        32'(m_err));
    chk("valid",      32'(o_valid),      32'(m_valid));
    chk("data",       32'(o_data),       32'(m_data));
  endtask

  task automatic step();
    @(negedge i_clk);
    if (chk_en) begin
      compare();
      if (o_cic_clr) n_clr++;
      if (o_dec_strobe) strobe_q.push_back(cyc);
      if (o_valid && first_valid < 0) begin
        first_valid = cyc;
        first_data  = o_data;
      end
      model_edge();
    end
    @(posedge i_clk);
    #1;
    cyc++;
  endtask

  task automatic wait_valid(input string nm, input int lim);
    int k;
    k = 0;
    while (!o_valid && k < lim) begin
      step();
      k++;
    end
    chk(nm, 32'(o_valid), 32'd1);
  endtask

  // D=4, constant input 5, continuous valid/ready.
  task automatic run_first_scenario();
    int start_cyc;
    i_decim = 5'd4; src_x = 20'd5; i_in_valid = 1; i_ready = 1;
    n_clr = 0; strobe_q.delete(); first_valid = -1; first_data = '0;
    start_cyc = cyc;
    i_start = 1; step(); i_start = 0;
    for (int i = 0; i < 24; i++) step();
    chk("A_clr_pulses", 32'(n_clr), 32'd1);
    if (strobe_q.size() >= 4) begin
      chk("A_strobe_gap", 32'(strobe_q[1] - strobe_q[0]), 32'd4);
      chk("A_first_strobe", 32'(strobe_q[0] - start_cyc), 32'd5);
      chk("A_latency", 32'(first_valid - strobe_q[3]), 32'd2);
    end else begin
      chk("A_strobe_count", 32'(strobe_q.size()), 32'd4);
    end
    chk("A_first_valid", 32'(first_valid - start_cyc), 32'd19);
    chk("A_first_data", 32'(first_data), 32'd320);
    chk("A_in_ready", 32'(o_in_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [DW-1:0] held;
    int s0;
    int k;
    bit any_v;

    i_rst_an = 0; i_start = 0; i_stop = 0; i_decim = 5'd2;
    i_in_valid = 0; i_ready = 0; src_x = '0;
    @(posedge i_clk); #1;
    model_reset();
    chk_en = 1;
    step();
    i_rst_an = 1;
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_data", 32'(o_data), 32'd0);
    step();

    run_first_scenario();

    // Illegal D values, then a legal start.
    i_stop = 1; step(); i_stop = 0; i_in_valid = 0;
    for (int i = 0; i < 3; i++) step();
    i_decim = 5'd1; i_start = 1; step(); i_start = 0;
    chk("B_err_d1", 32'(o_err), 32'd1);
    chk("B_busy_d1", 32'(o_busy), 32'd0);
    chk("B_clr_d1", 32'(o_cic_clr), 32'd0);
    step();
    i_decim = 5'd17; i_start = 1; step(); i_start = 0;
    chk("B_err_d17", 32'(o_err), 32'd1);
    chk("B_clr_d17", 32'(o_cic_clr), 32'd0);
    i_decim = 5'd2; i_start = 1; step(); i_start = 0;
    chk("B_err_d2", 32'(o_err), 32'd0);
    chk("B_busy_d2", 32'(o_busy), 32'd1);

    // D=2 backpressure.
    i_in_valid = 1; i_ready = 1;
    wait_valid("C_wait_valid", 40);
    i_ready = 0;
    held = o_data;
    chk("C_first_data", 32'(held), 32'd40);
    s0 = strobe_q.size();
    for (int i = 0; i < 10; i++) step();
    chk("C_data_held", 32'(o_data), 32'(held));
    chk("C_no_strobe", 32'(strobe_q.size() - s0), 32'd0);
    chk("C_ready_low", 32'(o_in_ready), 32'd0);
    i_ready = 1;
    for (int i = 0; i < 20; i++) step();

    // Stop in a strobe cycle.
    #1;
    k = 0;
    model_comb();
    while (!e_strobe && k < 20) begin
      step();
      model_comb();
      k++;
    end
    chk("D_strobe_now", 32'(o_dec_strobe), 32'd1);
    i_stop = 1; step(); i_stop = 0;
    chk("D_busy", 32'(o_busy), 32'd0);
    any_v = o_valid;
    for (int i = 0; i < 4; i++) begin
      step();
      any_v |= o_valid;
    end
    chk("D_no_new_valid", 32'(any_v), 32'd0);

    // Stop while a sample is held.
    i_decim = 5'd2; i_start = 1; step(); i_start = 0;
    wait_valid("D2_wait_valid", 40);
    i_ready = 0;
    held = o_data;
    step(); step();
    i_stop = 1; step(); i_stop = 0;
    chk("D2_busy", 32'(o_busy), 32'd0);
    chk("D2_valid_held", 32'(o_valid), 32'd1);
    chk("D2_data_held", 32'(o_data), 32'(held));
    for (int i = 0; i < 3; i++) step();
    chk("D2_valid_still", 32'(o_valid), 32'd1);
    i_ready = 1; step();
    chk("D2_valid_gone", 32'(o_valid), 32'd0);

    // Start and stop together in idle.
    i_start = 1; i_stop = 1; step(); i_start = 0; i_stop = 0;
    chk("E_busy", 32'(o_busy), 32'd0);
    chk("E_clr", 32'(o_cic_clr), 32'd0);
    step();

    // Reset in RUN with a held sample, then restart.
    i_decim = 5'd4; i_in_valid = 1; i_ready = 1;
    i_start = 1; step(); i_start = 0;
    wait_valid("F_wait_valid", 60);
    i_ready = 0; step();
    i_rst_an = 0; step(); i_rst_an = 1;
    chk("F_valid", 32'(o_valid), 32'd0);
    chk("F_data", 32'(o_data), 32'd0);
    chk("F_busy", 32'(o_busy), 32'd0);
    chk("F_err", 32'(o_err), 32'd0);
    chk("F_clr", 32'(o_cic_clr), 32'd0);
    chk("F_ready", 32'(o_in_ready), 32'd0);
    chk("F_strobe", 32'(o_dec_strobe), 32'd0);
    chk("F_ena", 32'(o_cic_ena), 32'd0);
    run_first_scenario();

    // Randomised traffic against the model.
    for (int i = 0; i < 800; i++) begin
      i_in_valid = ($urandom_range(0, 3) != 0);
      i_ready    = ($urandom_range(0, 3) != 0);
      src_x      = DW'($urandom);
      i_start    = ($urandom_range(0, 19) == 0);
      i_stop     = ($urandom_range(0, 59) == 0);
      i_decim    = DECW'($urandom_range(0, 20));
      i_rst_an   = ($urandom_range(0, 299) != 0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
